// File: rtl/sample_row_reader_if.sv
// Output sample stream from the row reader to the interpolation filter.
// Latency: n/a (wires only).
// Backpressure: out_ready from the slave holds the master's current sample.
interface sample_row_reader_if #(
   parameter int DATA_W = 8
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [3:0]        out_idx;

   modport master (output out_valid, output out_data, output out_idx, input out_ready);
   modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/sample_row_reader.sv
// Sample buffer plus read sequencer: streams len samples walking idx by step (mod 16).
// Latency: first sample valid the cycle after start is accepted; done one cycle after last handshake.
// Backpressure: out_ready low holds idx, out_data and out_idx; buffer writes ignored while busy.
module sample_row_reader #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [3:0]        wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              start,
   input  logic [4:0]        len,
   input  logic [3:0]        step,
   output logic              busy,
   output logic              done,
   sample_row_reader_if.master out_if
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [3:0]        idx_q;
   logic [4:0]        rem_q;
   logic [3:0]        step_q;
   logic              hs;

   assign hs = (state_q == RUN) && out_if.out_ready;

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == 5'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (hs && rem_q == 5'd1) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencer datapath: latch len/step on start, advance idx on each handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         rem_q  <= '0;
         step_q <= '0;
      end else if (state_q == IDLE) begin
         if (start && len != 5'd0) begin
            rem_q  <= len;
            step_q <= step;
            idx_q  <= '0;
         end
      end else if (hs) begin
         rem_q <= rem_q - 5'd1;
         idx_q <= idx_q + step_q;
      end
   end

   // Buffer writes only in IDLE so the data is frozen while streaming.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state_q == IDLE && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Outputs decode directly from state and the registered index.
   always_comb begin
      out_if.out_valid = (state_q == RUN);
      out_if.out_idx   = idx_q;
      out_if.out_data  = mem[idx_q];
      done             = (state_q == DONE);
      busy             = (state_q != IDLE);
   end

endmodule
